// File: rtl/irq_pending_latch.sv
// Request-capture stage ahead of the 8-to-3 priority encoder: edge capture, masking, one-in-service handshake.
// Define IRQ_LEVEL_MODE_EN for level-sensitive capture (pending follows req, a legal ack does not clear it).
module irq_pending_latch #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            mask_we,
    input  logic [N-1:0]    mask_wdata,
    output logic [N-1:0]    mask,
    output logic [N-1:0]    pend_o,
    output logic            enc_en,
    output logic            irq,
    input  logic            ack,
    input  logic [ID_W-1:0] ack_id,
    output logic            in_service,
    output logic [ID_W-1:0] isr_id,
    input  logic            eoi,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SERVICE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] pending;
    logic [N-1:0] pending_nxt;
    logic         any_pend;
    logic         legal_ack;
    logic         legal_eoi;
    logic         err_nxt;

    assign pend_o     = pending & mask;
    assign any_pend   = |pend_o;
    assign irq        = (state == ARMED);
    assign enc_en     = (state == ARMED);
    assign in_service = (state == SERVICE);

    // Only the strobe that matches the current state is legal; the other one flags err.
    always_comb begin
        state_nxt = state;
        legal_ack = 1'b0;
        legal_eoi = 1'b0;
        case (state)
            IDLE: begin
                if (any_pend)
                    state_nxt = ARMED;
            end
            ARMED: begin
                if (ack && pend_o[ack_id]) begin
                    legal_ack = 1'b1;
                    state_nxt = SERVICE;
                end else if (!any_pend) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    legal_eoi = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        err_nxt = (ack && !legal_ack) || (eoi && !legal_eoi);
    end

`ifdef IRQ_LEVEL_MODE_EN
    assign pending_nxt = req;
`else
    logic [N-1:0] req_q;
    logic [N-1:0] clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            req_q <= '0;
        else
            req_q <= req;
    end

    // A new edge on the bit being acknowledged wins over the clear.
    assign clr         = legal_ack ? ({{(N-1){1'b0}}, 1'b1} << ack_id) : '0;
    assign pending_nxt = (pending & ~clr) | (req & ~req_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            mask    <= '0;
            isr_id  <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            err     <= err_nxt;
            if (mask_we)
                mask <= mask_wdata;
            if (legal_ack)
                isr_id <= ack_id;
        end
    end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: directed scenarios then randomized traffic against a behavioural model.
// Honours IRQ_LEVEL_MODE_EN in the reference model so either build can be checked.
module tb_irq_pending_latch;

    localparam int M_IDLE    = 0;
    localparam int M_ARMED   = 1;
    localparam int M_SERVICE = 2;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic [7:0] pend_o;
    logic       enc_en;
    logic       irq;
    logic       ack;
    logic [2:0] ack_id;
    logic       in_service;
    logic [2:0] isr_id;
    logic       eoi;
    logic       err;

    int checks_done   = 0;
    int checks_passed = 0;
    int cycle_count   = 0;

    logic [7:0] m_req_q;
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    int         m_mode;
    logic [2:0] m_isr;
    logic       m_err;

    irq_pending_latch #(.N(8), .ID_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pend_o     (pend_o),
        .enc_en     (enc_en),
        .irq        (irq),
        .ack        (ack),
        .ack_id     (ack_id),
        .in_service (in_service),
        .isr_id     (isr_id),
        .eoi        (eoi),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_done++;
        if (observed !== expected)
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle_count, observed, expected);
        else
            checks_passed++;
    endtask

    function automatic void modelReset();
        m_req_q = 8'h00;
        m_pend  = 8'h00;
        m_mask  = 8'h00;
        m_mode  = M_IDLE;
        m_isr   = 3'd0;
        m_err   = 1'b0;
    endfunction

    // Reference behaviour: next state computed from the rules, one bit at a time for pending.
    function automatic void modelStep(input logic [7:0] r, input logic mw, input logic [7:0] md,
                                      input logic a, input logic [2:0] aid, input logic e);
        logic [7:0] vis;
        logic [7:0] np;
        logic       good_ack;
        logic       good_eoi;
        vis      = m_pend & m_mask;
        good_ack = a && (m_mode == M_ARMED) && vis[aid];
        good_eoi = e && (m_mode == M_SERVICE);
        m_err    = (a && !good_ack) || (e && !good_eoi);
`ifdef IRQ_LEVEL_MODE_EN
        np = r;
`else
        for (int i = 0; i < 8; i++) begin
            if (r[i] && !m_req_q[i])
                np[i] = 1'b1;
            else if (good_ack && int'(aid) == i)
                np[i] = 1'b0;
            else
                np[i] = m_pend[i];
        end
        m_req_q = r;
`endif
        m_pend = np;
        if (good_ack) begin
            m_isr  = aid;
            m_mode = M_SERVICE;
        end else if (m_mode == M_ARMED && vis == 8'h00) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE && vis != 8'h00) begin
            m_mode = M_ARMED;
        end else if (good_eoi) begin
            m_mode = M_IDLE;
        end
        if (mw)
            m_mask = md;
    endfunction

    task automatic checkAll();
        checkOutput("mask",       32'(mask),       32'(m_mask));
        checkOutput("pend_o",     32'(pend_o),     32'(m_pend & m_mask));
        checkOutput("irq",        32'(irq),        32'(m_mode == M_ARMED));
        checkOutput("enc_en",     32'(enc_en),     32'(m_mode == M_ARMED));
        checkOutput("in_service", 32'(in_service), 32'(m_mode == M_SERVICE));
        checkOutput("isr_id",     32'(isr_id),     32'(m_isr));
        checkOutput("err",        32'(err),        32'(m_err));
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic mw, input logic [7:0] md,
                                 input logic a, input logic [2:0] aid, input logic e);
        req        = r;
        mask_we    = mw;
        mask_wdata = md;
        ack        = a;
        ack_id     = aid;
        eoi        = e;
        modelStep(r, mw, md, a, aid, e);
        @(posedge clk);
        #1;
        cycle_count++;
        checkAll();
    endtask

    // Reset is raised between edges so its asynchronous effect is visible before any clock.
    task automatic doReset();
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] md;
        logic [7:0] vis;
        logic [2:0] aid;
        logic       mw;
        logic       a;
        logic       e;
        int         start;

        rst        = 1'b1;
        req        = 8'h00;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        ack        = 1'b0;
        ack_id     = 3'd0;
        eoi        = 1'b0;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkAll();
        rst = 1'b0;

        // Single pulse on req[5] reaches irq one cycle after capture.
        applyStimulus(8'h00, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0);
        applyStimulus(8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
`ifndef IRQ_LEVEL_MODE_EN
        checkOutput("t1_pend", 32'(pend_o), 32'h20);
        checkOutput("t1_irq_early", 32'(irq), 32'h0);
`endif
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
`ifndef IRQ_LEVEL_MODE_EN
        checkOutput("t1_irq", 32'(irq), 32'h1);
        checkOutput("t1_enc_en", 32'(enc_en), 32'h1);
        checkOutput("t1_pend_o", 32'(pend_o), 32'h20);
`endif

        // Acknowledge line 7 out of 8'hA0, then end service and re-arm on the remainder.
        applyStimulus(8'h80, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 3'd7, 1'b0);
`ifndef IRQ_LEVEL_MODE_EN
        checkOutput("t2_pend", 32'(pend_o), 32'h20);
        checkOutput("t2_isr_id", 32'(isr_id), 32'd7);
        checkOutput("t2_in_service", 32'(in_service), 32'h1);
        checkOutput("t2_irq", 32'(irq), 32'h0);
`endif
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
`ifndef IRQ_LEVEL_MODE_EN
        checkOutput("t2_rearm", 32'(irq), 32'h1);
`endif

        // Acknowledge of a line that is not pending flags err for one cycle only.
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0);
`ifndef IRQ_LEVEL_MODE_EN
        checkOutput("t3_err", 32'(err), 32'h1);
        checkOutput("t3_irq", 32'(irq), 32'h1);
        checkOutput("t3_pend", 32'(pend_o), 32'h20);
`endif
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
`ifndef IRQ_LEVEL_MODE_EN
        checkOutput("t3_err_clear", 32'(err), 32'h0);
`endif

        // Ack of line 4 coincides with a fresh edge on line 4: the bit stays set.
        applyStimulus(8'h10, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(8'h10, 1'b0, 8'h00, 1'b1, 3'd4, 1'b0);
`ifndef IRQ_LEVEL_MODE_EN
        checkOutput("t5_pend", 32'(pend_o), 32'h30);
        checkOutput("t5_isr_id", 32'(isr_id), 32'd4);
`endif
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
`ifndef IRQ_LEVEL_MODE_EN
        checkOutput("t5_eoi_idle_err", 32'(err), 32'h1);
`endif

        // Fill pending to 8'hFF while in service, then reset with req=8'h81 held.
        applyStimulus(8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
        applyStimulus(8'hFE, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
`ifndef IRQ_LEVEL_MODE_EN
        checkOutput("t6_pend_full", 32'(pend_o), 32'hFF);
        checkOutput("t6_in_service", 32'(in_service), 32'h1);
`endif
        req = 8'h81;
        doReset();
        checkOutput("t6_rst_pend_o", 32'(pend_o), 32'h0);
        checkOutput("t6_rst_in_service", 32'(in_service), 32'h0);
        applyStimulus(8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(8'h81, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0);
        checkOutput("t6_captured", 32'(pend_o), 32'h81);

        // Masked line still captures; unmasking raises irq two cycles after the write.
        req = 8'h00;
        doReset();
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        checkOutput("t4_masked", 32'(pend_o), 32'h0);
        applyStimulus(8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        checkOutput("t4_irq_masked", 32'(irq), 32'h0);
        applyStimulus(8'h01, 1'b1, 8'h01, 1'b0, 3'd0, 1'b0);
        checkOutput("t4_irq_write", 32'(irq), 32'h0);
        applyStimulus(8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        checkOutput("t4_irq_unmasked", 32'(irq), 32'h1);

        // Randomized traffic, with acks biased toward visible lines and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0)
                doReset();
            r   = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            mw  = ($urandom_range(0, 9) == 0);
            md  = 8'($urandom) | 8'($urandom);
            a   = ($urandom_range(0, 3) == 0);
            e   = ($urandom_range(0, 3) == 0);
            aid = 3'($urandom_range(0, 7));
            vis = m_pend & m_mask;
            if (vis != 8'h00 && $urandom_range(0, 2) != 0) begin
                start = int'($urandom_range(0, 7));
                for (int k = 7; k >= 0; k--) begin
                    if (vis[(start + k) % 8])
                        aid = 3'((start + k) % 8);
                end
            end
            applyStimulus(r, mw, md, a, aid, e);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_done);
        $finish;
    end

endmodule
